// File: rtl/sme_job_buffer.sv
// Double-buffered string/pattern job loader with valid/ready output and overflow tracking.
// Define SME_CLEAR_ON_LOAD_EN to zero a bank's data on the first write of each job.
module sme_job_buffer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STR_DEPTH = 32,
  parameter int unsigned PAT_DEPTH = 8,
  localparam int unsigned SL_W     = $clog2(STR_DEPTH + 1),
  localparam int unsigned PL_W     = $clog2(PAT_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           w_data,
  input  logic                        write,
  input  logic                        w_sel,
  output logic                        w_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [STR_DEPTH*DATA_W-1:0] out_str,
  output logic [PAT_DEPTH*DATA_W-1:0] out_pat,
  output logic [SL_W-1:0]             out_str_len,
  output logic [PL_W-1:0]             out_pat_len,
  output logic                        out_ovf
);

  localparam int unsigned SI_W = $clog2(STR_DEPTH);
  localparam int unsigned PI_W = $clog2(PAT_DEPTH);
  localparam logic [SL_W-1:0] STR_MAX = SL_W'(STR_DEPTH);
  localparam logic [PL_W-1:0] PAT_MAX = PL_W'(PAT_DEPTH);

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [STR_DEPTH*DATA_W-1:0] str_q     [2];
  logic [PAT_DEPTH*DATA_W-1:0] pat_q     [2];
  logic [SL_W-1:0]             str_cnt_q [2];
  logic [PL_W-1:0]             pat_cnt_q [2];
  logic                        ovf_q     [2];
  logic [1:0]                  state_q   [2];
  logic                        wr_bank_q;
  logic                        rd_bank_q;

  logic [1:0]      wr_state;
  logic [1:0]      rd_state;
  logic            accept;
  logic            commit;
  logic            rel_job;
  logic            first_wr;
  logic [SL_W-1:0] cur_str_cnt;
  logic [PL_W-1:0] cur_pat_cnt;
  logic            cur_ovf;
  logic [SL_W-1:0] str_cnt_d;
  logic [PL_W-1:0] pat_cnt_d;
  logic            ovf_d;
  logic            str_wr;
  logic            pat_wr;
  logic [SI_W-1:0] str_idx;
  logic [PI_W-1:0] pat_idx;

  always_comb begin
    wr_state  = state_q[wr_bank_q];
    rd_state  = state_q[rd_bank_q];
    w_ready   = (wr_state != ST_FULL);
    out_valid = (rd_state == ST_FULL);
    accept    = write && w_ready;
    commit    = !write && (wr_state == ST_LOADING);
    rel_job   = out_valid && out_ready;
    first_wr  = (wr_state == ST_FREE);

    // A FREE bank starts a fresh job: its stale counts and flag are ignored.
    cur_str_cnt = first_wr ? '0 : str_cnt_q[wr_bank_q];
    cur_pat_cnt = first_wr ? '0 : pat_cnt_q[wr_bank_q];
    cur_ovf     = first_wr ? 1'b0 : ovf_q[wr_bank_q];

    str_cnt_d = cur_str_cnt;
    pat_cnt_d = cur_pat_cnt;
    ovf_d     = cur_ovf;
    str_wr    = 1'b0;
    pat_wr    = 1'b0;
    if (!w_sel) begin
      if (cur_str_cnt == STR_MAX) begin
        ovf_d = 1'b1;
      end else begin
        str_cnt_d = cur_str_cnt + SL_W'(1);
        str_wr    = 1'b1;
      end
    end else begin
      if (cur_pat_cnt == PAT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pat_cnt_d = cur_pat_cnt + PL_W'(1);
        pat_wr    = 1'b1;
      end
    end
    str_idx = cur_str_cnt[SI_W-1:0];
    pat_idx = cur_pat_cnt[PI_W-1:0];
  end

  always_comb begin
    out_str     = str_q[rd_bank_q];
    out_pat     = pat_q[rd_bank_q];
    out_str_len = str_cnt_q[rd_bank_q];
    out_pat_len = pat_cnt_q[rd_bank_q];
    out_ovf     = ovf_q[rd_bank_q];
  end

  // Load and release always target different banks, so both may update in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        str_q[b]     <= '0;
        pat_q[b]     <= '0;
        str_cnt_q[b] <= '0;
        pat_cnt_q[b] <= '0;
        ovf_q[b]     <= 1'b0;
        state_q[b]   <= ST_FREE;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      if (accept) begin
        if (first_wr) begin
          state_q[wr_bank_q] <= ST_LOADING;
`ifdef SME_CLEAR_ON_LOAD_EN
          str_q[wr_bank_q] <= '0;
          pat_q[wr_bank_q] <= '0;
`endif
        end
        str_cnt_q[wr_bank_q] <= str_cnt_d;
        pat_cnt_q[wr_bank_q] <= pat_cnt_d;
        ovf_q[wr_bank_q]     <= ovf_d;
        if (str_wr) begin
          str_q[wr_bank_q][str_idx*DATA_W +: DATA_W] <= w_data;
        end
        if (pat_wr) begin
          pat_q[wr_bank_q][pat_idx*DATA_W +: DATA_W] <= w_data;
        end
      end
      if (commit) begin
        state_q[wr_bank_q] <= ST_FULL;
        wr_bank_q          <= ~wr_bank_q;
      end
      if (rel_job) begin
        state_q[rd_bank_q] <= ST_FREE;
        rd_bank_q          <= ~rd_bank_q;
      end
    end
  end

endmodule

// File: tb/tb_sme_job_buffer.sv
// Bench for sme_job_buffer: directed vector table, corner sequences and a random run
// checked against a job-queue reference model.
module tb_sme_job_buffer;

  localparam int DW  = 8;
  localparam int SD  = 32;
  localparam int PD  = 8;
  localparam int SLW = 6;
  localparam int PLW = 4;
  localparam int SW  = SD * DW;
  localparam int PW  = PD * DW;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  w_data;
  logic           write;
  logic           w_sel;
  logic           w_ready;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_str;
  logic [PW-1:0]  out_pat;
  logic [SLW-1:0] out_str_len;
  logic [PLW-1:0] out_pat_len;
  logic           out_ovf;

  always #5 clk = ~clk;

  sme_job_buffer #(
    .DATA_W   (DW),
    .STR_DEPTH(SD),
    .PAT_DEPTH(PD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w_data     (w_data),
    .write      (write),
    .w_sel      (w_sel),
    .w_ready    (w_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_str    (out_str),
    .out_pat    (out_pat),
    .out_str_len(out_str_len),
    .out_pat_len(out_pat_len),
    .out_ovf    (out_ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a FIFO of committed jobs plus the job being loaded.
  typedef struct {
    logic [SW-1:0] s;
    logic [PW-1:0] p;
    int            sl;
    int            pl;
    bit            ovf;
  } job_t;

  job_t fifo[$];
  job_t cur;
  bit   loading;

  task automatic model_reset();
    fifo.delete();
    loading = 1'b0;
  endtask

  task automatic model_step(input bit w, input bit s, input logic [7:0] d, input bit r);
    bit rel;
    bit com;
    rel = (fifo.size() > 0) && r;
    com = 1'b0;
    if (w && fifo.size() < 2) begin
      if (!loading) begin
        loading = 1'b1;
        cur.s = '0; cur.p = '0; cur.sl = 0; cur.pl = 0; cur.ovf = 1'b0;
      end
      if (!s) begin
        if (cur.sl == SD) cur.ovf = 1'b1;
        else begin cur.s[cur.sl*8 +: 8] = d; cur.sl++; end
      end else begin
        if (cur.pl == PD) cur.ovf = 1'b1;
        else begin cur.p[cur.pl*8 +: 8] = d; cur.pl++; end
      end
    end else if (!w && loading) begin
      com = 1'b1;
    end
    if (rel) void'(fifo.pop_front());
    if (com) begin
      fifo.push_back(cur);
      loading = 1'b0;
    end
  endtask

  function automatic logic [SW-1:0] mask_s(input logic [SW-1:0] v, input int len);
    for (int i = 0; i < SD; i++) if (i >= len) v[i*8 +: 8] = '0;
    return v;
  endfunction

  function automatic logic [PW-1:0] mask_p(input logic [PW-1:0] v, input int len);
    for (int i = 0; i < PD; i++) if (i >= len) v[i*8 +: 8] = '0;
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, out_valid, fifo.size() > 0);
    chk({tag, "_wready"}, w_ready, fifo.size() < 2);
    if (fifo.size() > 0) begin
      chk({tag, "_slen"}, out_str_len, fifo[0].sl);
      chk({tag, "_plen"}, out_pat_len, fifo[0].pl);
      chk({tag, "_ovf"}, out_ovf, fifo[0].ovf);
      chk({tag, "_str"}, mask_s(out_str, fifo[0].sl), fifo[0].s);
      chk({tag, "_pat"}, mask_p(out_pat, fifo[0].pl), fifo[0].p);
    end
  endtask

  task automatic step(input bit w, input bit s, input logic [7:0] d, input bit r);
    write = w; w_sel = s; w_data = d; out_ready = r;
    @(posedge clk);
    model_step(w, s, d, r);
    #1;
  endtask

  task automatic do_reset(input bit w);
    reset = 1'b1; write = w; w_sel = 1'b0; w_data = 8'h5a; out_ready = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit         w;
    bit         s;
    logic [7:0] d;
    bit         r;
    bit         ev;
    bit         er;
    int         sl;
    int         pl;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 0, 8'h41, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 8'h42, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 8'h43, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 8'h44, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 1, 8'h42, 0, 0, 1, 0, 0};
    tbl[5]  = '{1, 1, 8'h43, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 8'h00, 0, 1, 1, 4, 2};
    tbl[7]  = '{0, 0, 8'h00, 0, 1, 1, 4, 2};
    tbl[8]  = '{1, 0, 8'h58, 0, 1, 1, 4, 2};
    tbl[9]  = '{1, 0, 8'h59, 0, 1, 1, 4, 2};
    tbl[10] = '{0, 0, 8'h00, 0, 1, 0, 4, 2};
    tbl[11] = '{1, 0, 8'h5a, 0, 1, 0, 4, 2};
    tbl[12] = '{0, 0, 8'h00, 1, 1, 1, 2, 0};
    tbl[13] = '{0, 0, 8'h00, 1, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 8'h00, 0, 0, 1, 0, 0};

    model_reset();
    do_reset(1'b0);
    do_reset(1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_wready", w_ready, 1'b1);
    chk("rst_slen", out_str_len, 0);
    chk("rst_plen", out_pat_len, 0);
    chk("rst_ovf", out_ovf, 1'b0);
    chk("rst_str", out_str, '0);
    chk("rst_pat", out_pat, '0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].w, tbl[i].s, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d_wready", i), w_ready, tbl[i].er);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_slen", i), out_str_len, tbl[i].sl);
        chk($sformatf("vec%0d_plen", i), out_pat_len, tbl[i].pl);
      end
      if (i == 7 || i == 11) begin
        chk($sformatf("vec%0d_str0", i), out_str[7:0], 8'h41);
        chk($sformatf("vec%0d_pat1", i), out_pat[15:8], 8'h43);
      end
      if (i == 12) chk("vec12_str1", out_str[15:8], 8'h59);
    end

    // Pattern overflow: 10 chars into an 8-deep pattern store.
    for (int i = 0; i < 10; i++) step(1, 1, 8'(8'h10 + i), 0);
    step(0, 0, 8'h00, 0);
    chk("ovf_valid", out_valid, 1'b1);
    chk("ovf_plen", out_pat_len, 8);
    chk("ovf_flag", out_ovf, 1'b1);
    chk("ovf_last", out_pat[63:56], 8'h17);
    step(0, 0, 8'h00, 1);

    // Six-char job, a filler job, then a three-char job in the same bank.
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h61 + i), 0);
    step(0, 0, 8'h00, 0);
    chk("six_slen", out_str_len, 6);
    chk("six_ovf", out_ovf, 1'b0);
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h55, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h78, 0);
    step(1, 0, 8'h79, 0);
    step(1, 0, 8'h7a, 0);
    step(0, 0, 8'h00, 0);
    chk("three_slen", out_str_len, 3);
    chk("three_head", out_str[23:0], 24'h7a7978);
`ifdef SME_CLEAR_ON_LOAD_EN
    chk("three_tail", out_str[47:24], 24'h000000);
`else
    chk("three_tail", out_str[47:24], 24'h666564);
`endif
    check_model("three");
    step(0, 0, 8'h00, 1);

    // Reset while one bank is FULL and the other is loading.
    step(1, 0, 8'h31, 0);
    step(1, 1, 8'h32, 0);
    step(0, 0, 8'h00, 0);
    step(1, 0, 8'h33, 0);
    step(1, 0, 8'h34, 0);
    do_reset(1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_wready", w_ready, 1'b1);
    chk("mid_rst_slen", out_str_len, 0);
    chk("mid_rst_plen", out_pat_len, 0);
    chk("mid_rst_str", out_str, '0);

    // Random traffic with backpressure.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 3) == 0);
      check_model($sformatf("rnd%0d", c));
    end
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 8'h00, 1);
      check_model("drain");
    end

    // Always-ready consumer with back-to-back jobs separated by one idle cycle.
    for (int j = 0; j < 40; j++) begin
      int k;
      k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++) begin
        step(1, $urandom_range(0, 1) == 1, 8'($urandom), 1);
        check_model($sformatf("b2b%0d_w%0d", j, i));
      end
      step(0, 0, 8'h00, 1);
      check_model($sformatf("b2b%0d_idle", j));
    end
    step(0, 0, 8'h00, 1);
    check_model("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sme_job_buffer.md
Name: sme_job_buffer

Overview:
- Parametrised, double-buffered loader for string-matching jobs in the SME datapath.
- Accepts a serial byte stream of string and pattern characters, one per cycle, and commits each job into one of two banks.
- Presents committed jobs to the matcher/slave array through a valid/ready handshake, so job N+1 can load while job N is processed.
- Adds over the single-bank loader: parametrised widths and depths, ping-pong banking, output backpressure, length counts (0 is legal) and an overflow flag.

Parameters:
- DATA_W, 8, bits per character
- STR_DEPTH, 32, max string characters per job (>=2)
- PAT_DEPTH, 8, max pattern characters per job (>=2)
- Derived localparams: SL_W = clog2(STR_DEPTH+1), PL_W = clog2(PAT_DEPTH+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- w_data  in  DATA_W  character to store
- write  in  1  character strobe; a job is a contiguous run of write=1 cycles
- w_sel  in  1  0 = string, 1 = pattern
- w_ready  out  1  load bank available; writes ignored when 0
- out_valid  out  1  committed job presented
- out_ready  in  1  consumer accepts the job
- out_str  out  STR_DEPTH*DATA_W  char i at [i*DATA_W +: DATA_W]
- out_pat  out  PAT_DEPTH*DATA_W  same packing
- out_str_len  out  SL_W  string characters stored (0..STR_DEPTH)
- out_pat_len  out  PL_W  pattern characters stored (0..PAT_DEPTH)
- out_ovf  out  1  job dropped at least one character

Behaviour:
- Two banks, each with data, str_cnt, pat_cnt, ovf and state FREE/LOADING/FULL. Pointers: wr_bank and rd_bank, both 1 bit.
- Reset: both banks FREE with all data, counts and ovf = 0; wr_bank = rd_bank = 0.
  - Outputs after reset: out_valid = 0, w_ready = 1, all out_* = 0.
  - Reset mid-load or mid-handshake discards everything.
- w_ready = (state[wr_bank] != FULL). It is a combinational decode of registered state.
- Accepted write = write && w_ready. When the bank is FREE, the first accepted write moves it to LOADING and clears its str_cnt, pat_cnt and ovf before applying that write.
- Store: w_sel = 0 writes char str_cnt and increments str_cnt; w_sel = 1 does the same on the pattern side. String and pattern writes may interleave freely.
- Overflow: a write when the selected count equals its DEPTH is dropped and sets ovf. The count saturates at DEPTH; it never wraps.
- Commit: a cycle with write = 0 while state[wr_bank] == LOADING sets the bank to FULL and toggles wr_bank.
  - Timing: last write in cycle N, idle in N+1, out_valid high in N+2 (if rd_bank points at that bank).
- out_valid = (state[rd_bank] == FULL). All out_* are driven from bank rd_bank and held stable while out_valid && !out_ready.
- Handshake: out_valid && out_ready at a clock edge sets bank rd_bank to FREE and toggles rd_bank. If the other bank is FULL, out_valid stays 1 with the new job; there is no bubble.
- Simultaneous release and commit (or release and write) act on different banks and are both honoured in the same cycle.
- Both banks FULL: w_ready = 0 and writes are ignored; no state change.
- out_ready while out_valid = 0 is ignored.
- Jobs are delivered in load order (strict FIFO of depth 2).

Optional Feature:
- Macro: SME_CLEAR_ON_LOAD_EN.
- Defined: on a job's first accepted write, the bank's string and pattern data are zeroed in the same cycle. Character positions at or beyond the lengths read as 0.
- Undefined: unused positions keep the previous job's bytes, and consumers must mask with the lengths. Reset still zeroes the data.

Test Plan:
- Reset, then write string "ABCD" (w_sel = 0) and pattern "BC" (w_sel = 1), then idle, with out_ready held 0 -> out_valid = 1 exactly two cycles after the last write; out_str_len = 4, out_pat_len = 2; out_str[7:0] = 0x41, out_pat[15:8] = 0x43; outputs stable until out_ready.
- Load job A, then job B, with out_ready = 0 -> w_ready = 0 after B commits. A third stream is ignored. Pulse out_ready -> out_valid stays 1 and presents B; w_ready returns to 1 the next cycle.
- Write 10 pattern chars with PAT_DEPTH = 8 -> out_pat_len = 8, out_ovf = 1, chars 8 and 9 dropped. The next job clears out_ovf to 0.
- A job of 3 string chars after a job of 6 -> out_str_len = 3. Positions 3..5 read 0 with SME_CLEAR_ON_LOAD_EN defined, and hold the old bytes without it.
- Assert reset during a load with one bank FULL -> out_valid = 0, w_ready = 1, both lengths 0 on the following cycle.
- Set out_ready = 1 permanently and stream back-to-back jobs separated by one idle cycle -> each job appears once, in order, with no loss.
